// File: rtl/vga_text_writer.sv
// Purpose  : writer side of the VGA text buffer; turns an ASCII stream into char RAM writes,
//            tracks the cursor, handles CR/LF, line wrap and row clearing (rows wrap circularly).
// Latency  : one cycle from an accepting edge to the registered RAM write (wren/wraddress/data).
// Backpres.: ch_ready=1 only in IDLE; low for the whole power-up clear and each COLS-cycle row clear.
// Ports    : CLOCK_50/RST_N (sync active-low), ch_valid/ch_data/ch_ready char input,
//            wren/wraddress/data char RAM write port, cur_x/cur_y cursor, busy while clearing.
// Option   : define VGA_TEXT_WRITER_BACKSPACE_EN to make 0x08 erase the char left of the cursor.
module vga_text_writer #(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int AW   = 12
) (
    input  logic          CLOCK_50,
    input  logic          RST_N,
    input  logic          ch_valid,
    input  logic [7:0]    ch_data,
    output logic          ch_ready,
    output logic          wren,
    output logic [AW-1:0] wraddress,
    output logic [7:0]    data,
    output logic [6:0]    cur_x,
    output logic [4:0]    cur_y,
    output logic          busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CLR_ALL  = 2'd1;
    localparam logic [1:0] S_CLR_LINE = 2'd2;

    localparam int TOTAL = COLS * ROWS;

    logic [1:0]    state_q, state_d;
    logic [6:0]    cur_x_q, cur_x_d;
    logic [4:0]    cur_y_q, cur_y_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [6:0]    clr_cnt_q, clr_cnt_d;
    logic          wren_q, wren_d;
    logic [AW-1:0] wraddress_q, wraddress_d;
    logic [7:0]    data_q, data_d;

    logic [AW-1:0] wr_pos;
    logic [4:0]    next_row;
    logic          do_nl;

    assign wr_pos   = AW'(cur_y_q) * AW'(COLS) + AW'(cur_x_q);
    assign next_row = (cur_y_q == 5'(ROWS - 1)) ? 5'd0 : cur_y_q + 5'd1;

    always_comb begin
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        clr_addr_d  = clr_addr_q;
        clr_cnt_d   = clr_cnt_q;
        wren_d      = 1'b0;
        wraddress_d = wraddress_q;
        data_d      = data_q;
        do_nl       = 1'b0;

        case (state_q)
            S_CLR_ALL: begin
                wren_d      = 1'b1;
                wraddress_d = clr_addr_q;
                data_d      = 8'h00;
                if (clr_addr_q == AW'(TOTAL - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end

            S_CLR_LINE: begin
                wren_d      = 1'b1;
                wraddress_d = clr_addr_q;
                data_d      = 8'h00;
                clr_addr_d  = clr_addr_q + AW'(1);
                clr_cnt_d   = clr_cnt_q + 7'd1;
                if (clr_cnt_q == 7'(COLS - 1)) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (ch_valid) begin
                    if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
                        wren_d      = 1'b1;
                        wraddress_d = wr_pos;
                        data_d      = ch_data;
                        if (cur_x_q < 7'(COLS - 1)) begin
                            cur_x_d = cur_x_q + 7'd1;
                        end else begin
                            do_nl = 1'b1;
                        end
                    end else if (ch_data == 8'h0A) begin
                        do_nl = 1'b1;
                    end else if (ch_data == 8'h0D) begin
                        cur_x_d = 7'd0;
                    end
`ifdef VGA_TEXT_WRITER_BACKSPACE_EN
                    // Erase in place at the new cursor; never backs up into the previous row.
                    else if (ch_data == 8'h08 && cur_x_q != 7'd0) begin
                        cur_x_d     = cur_x_q - 7'd1;
                        wren_d      = 1'b1;
                        wraddress_d = wr_pos - AW'(1);
                        data_d      = 8'h00;
                    end
`endif
                end
            end

            default: state_d = S_CLR_ALL;
        endcase

        // Newline: the row being entered is cleared before any char can land in it.
        if (do_nl) begin
            cur_x_d    = 7'd0;
            cur_y_d    = next_row;
            state_d    = S_CLR_LINE;
            clr_addr_d = AW'(next_row) * AW'(COLS);
            clr_cnt_d  = 7'd0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            state_q     <= S_CLR_ALL;
            cur_x_q     <= 7'd0;
            cur_y_q     <= 5'd0;
            clr_addr_q  <= '0;
            clr_cnt_q   <= 7'd0;
            wren_q      <= 1'b0;
            wraddress_q <= '0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            clr_addr_q  <= clr_addr_d;
            clr_cnt_q   <= clr_cnt_d;
            wren_q      <= wren_d;
            wraddress_q <= wraddress_d;
            data_q      <= data_d;
        end
    end

    assign ch_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_CLR_ALL) || (state_q == S_CLR_LINE);
    assign wren      = wren_q;
    assign wraddress = wraddress_q;
    assign data      = data_q;
    assign cur_x     = cur_x_q;
    assign cur_y     = cur_y_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Purpose  : self-checking bench for vga_text_writer; expected RAM writes queued at stimulus time,
//            popped and compared by a monitor on every wren pulse.
// Latency  : outputs sampled on the falling edge, half a cycle after the registered write.
// Backpres.: stimulus waits for ch_ready before presenting each char.
module tb_vga_text_writer;

    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int AW   = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ch_valid = 1'b0;
    logic [7:0]    ch_data = 8'h00;
    logic          ch_ready;
    logic          wren;
    logic [AW-1:0] wraddress;
    logic [7:0]    data;
    logic [6:0]    cur_x;
    logic [4:0]    cur_y;
    logic          busy;

    vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_ready (ch_ready),
        .wren     (wren),
        .wraddress(wraddress),
        .data     (data),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    dat;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  wr_cnt = 0;

    // Reference cursor kept by the bench.
    int  mx = 0;
    int  my = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            wr_t e;
            wr_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data 0x%02h expected none", wraddress, data);
            end else begin
                e = exp_q.pop_front();
                if (wraddress !== e.addr || data !== e.dat) begin
                    n_err++;
                    $display("FAIL write: got addr %0d data 0x%02h expected addr %0d data 0x%02h",
                             wraddress, data, e.addr, e.dat);
                end
            end
        end
    end

    task automatic push_wr(input int a, input int d);
        wr_t w;
        w.addr = AW'(a);
        w.dat  = 8'(d);
        exp_q.push_back(w);
    endtask

    task automatic model_newline();
        mx = 0;
        my = (my == ROWS - 1) ? 0 : my + 1;
        for (int i = 0; i < COLS; i++) push_wr(my * COLS + i, 0);
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_wr(my * COLS + mx, int'(c));
            if (mx < COLS - 1) mx++;
            else model_newline();
        end else if (c == 8'h0A) begin
            model_newline();
        end else if (c == 8'h0D) begin
            mx = 0;
        end
`ifdef VGA_TEXT_WRITER_BACKSPACE_EN
        else if (c == 8'h08 && mx > 0) begin
            mx--;
            push_wr(my * COLS + mx, 0);
        end
`endif
    endtask

    // Present one char once ch_ready is seen; held for exactly one rising edge.
    task automatic send_char(input logic [7:0] c);
        int t;
        t = 0;
        @(negedge clk);
        while (ch_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (ch_ready !== 1'b1) begin
            check("ready_timeout", 0, 1);
        end else begin
            ch_valid = 1'b1;
            ch_data  = c;
            model_char(c);
            @(posedge clk);
            #1;
            ch_valid = 1'b0;
            check("cur_x", int'(cur_x), mx);
            check("cur_y", int'(cur_y), my);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || ch_ready !== 1'b1) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset_clear();
        for (int i = 0; i < COLS * ROWS; i++) push_wr(i, 0);
        mx = 0;
        my = 0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain("clr_all_drain", 3000);
        check("ready_after_clr", int'(ch_ready), 1);
        check("busy_after_clr", int'(busy), 0);
        check("cur_x_after_clr", int'(cur_x), 0);
        check("cur_y_after_clr", int'(cur_y), 0);
    endtask

    initial begin
        int cnt;
        int target;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wren", int'(wren), 0);
        check("rst_ready", int'(ch_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_wraddress", int'(wraddress), 0);
        check("rst_data", int'(data), 0);
        check("rst_cur_x", int'(cur_x), 0);

        // Power-up clear of all 2100 cells.
        do_reset_clear();

        // Single printable char.
        send_char(8'h41);
        wait_drain("char_A_drain", 50);

        // 70 chars from (0,0) wrap into row 1, followed by a 70-cycle clear with ch_ready low.
        send_char(8'h0D);
        for (int i = 0; i < COLS; i++) send_char(8'h42);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ch_ready === 1'b1) break;
            cnt++;
        end
        check("wrap_ready_low_cycles", cnt, COLS);
        wait_drain("wrap_drain", 200);
        check("wrap_cur_x", int'(cur_x), 0);
        check("wrap_cur_y", int'(cur_y), 1);

        // Move to (5,29), then LF wraps to row 0 and clears it.
        for (int i = 0; i < 28; i++) send_char(8'h0A);
        for (int i = 0; i < 5; i++) send_char(8'h78);
        check("pre_lf_cur_x", int'(cur_x), 5);
        check("pre_lf_cur_y", int'(cur_y), 29);
        send_char(8'h0A);
        check("lf_wrap_cur_x", int'(cur_x), 0);
        check("lf_wrap_cur_y", int'(cur_y), 0);
        wait_drain("lf_wrap_drain", 200);

        // Backspace at (3,2), then at column 0; ignored control codes.
        send_char(8'h0A);
        send_char(8'h0A);
        for (int i = 0; i < 3; i++) send_char(8'h79);
        send_char(8'h08);
`ifdef VGA_TEXT_WRITER_BACKSPACE_EN
        check("bs_cur_x", int'(cur_x), 2);
`else
        check("bs_cur_x", int'(cur_x), 3);
`endif
        send_char(8'h0D);
        send_char(8'h08);
        check("bs_col0_cur_x", int'(cur_x), 0);
        send_char(8'h01);
        send_char(8'h7F);
        check("ctrl_cur_x", int'(cur_x), 0);
        check("ctrl_cur_y", int'(cur_y), 2);
        wait_drain("bs_drain", 50);

        // Reset during a row clear, after 30 of its writes.
        target = wr_cnt + 30;
        send_char(8'h0A);
        cnt = 0;
        while (wr_cnt < target && cnt < 200) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        check("midclr_writes_seen", wr_cnt, target);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midclr_rst_wren", int'(wren), 0);
        check("midclr_rst_busy", int'(busy), 1);
        check("midclr_rst_cur_y", int'(cur_y), 0);
        do_reset_clear();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
